// File: rtl/if_fetch.sv
// Instruction-fetch stage: drives the next PC, issues single-outstanding word fetches and
// buffers returned instructions with their PCs in a small FIFO toward decode.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC_Q,
  output logic [31:0] PC_D,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IF_VALID,
  input  logic        IF_READY,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  entry_t            fifo_q [DEPTH];
  entry_t            fifo_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              full_c;
  logic              req_c;
  logic              valid_c;
  logic              push_c;
  logic              pop_c;
  logic [XLEN-1:0]   fetch_addr_c;
  logic [XLEN-1:0]   redirect_addr_c;

  // Next-state, FIFO bookkeeping and output decode
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    fifo_d          = fifo_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    push_c          = 1'b0;
    full_c          = (count_q == CNT_W'(DEPTH));
    req_c           = (state_q == S_REQ) && !full_c && !RST;
    valid_c         = (count_q != '0) && !REDIRECT && !RST;
    pop_c           = valid_c && IF_READY;
    fetch_addr_c    = PC_Q & ~XLEN'(3);
    redirect_addr_c = REDIRECT_PC & ~XLEN'(3);

    PC_D      = PC_Q;
    IMEM_REQ  = req_c;
    IMEM_ADDR = fetch_addr_c;
    IF_VALID  = valid_c;
    IF_PC     = fifo_q[rd_ptr_q].pc;
    IF_INSTR  = fifo_q[rd_ptr_q].instr;

    unique case (state_q)
      S_REQ: begin
        if (req_c && IMEM_GNT) begin
          if (REDIRECT) begin
            // Granted fetch is on the wrong path; its response must be swallowed.
            state_d = S_DROP;
          end else begin
            PC_D    = PC_Q + XLEN'(4);
            addr_d  = fetch_addr_c;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (IMEM_RVALID) begin
          push_c  = !REDIRECT;
          state_d = S_REQ;
        end else if (REDIRECT) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (IMEM_RVALID) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (REDIRECT) begin
      PC_D     = redirect_addr_c;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        fifo_d[wr_ptr_q].pc    = addr_q;
        fifo_d[wr_ptr_q].instr = IMEM_RDATA;
        wr_ptr_d               = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    if (RST) begin
      PC_D = RESET_PC;
    end
  end

  // State and FIFO registers; buffer storage needs no reset since count gates validity
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_REQ;
      addr_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: models the pc register and a latency-configurable instruction memory,
// checks every cycle against a queue-based reference, plus directed literal checks.
`timescale 1ns/1ps
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] PC_Q = 32'h0;
  logic [31:0] PC_D;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        IF_VALID;
  logic        IF_READY = 1'b1;
  logic [31:0] IF_INSTR;
  logic [31:0] IF_PC;

  if_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .PC_Q(PC_Q), .PC_D(PC_D),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .IF_VALID(IF_VALID), .IF_READY(IF_READY), .IF_INSTR(IF_INSTR), .IF_PC(IF_PC)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0] m_pc[$];
  logic [31:0] m_ins[$];
  bit          m_out = 1'b0;
  bit          m_stale = 1'b0;
  logic [31:0] m_addr = 32'h0;

  // delivered stream and last sampled outputs
  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pcd, s_pc, s_ins;

  // memory environment
  int          lat = 1;
  bit          env_pend = 1'b0;
  int          env_wait = 0;
  logic [31:0] env_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  function automatic bit exp_req();
    return !RST && !m_out && (m_pc.size() < DEPTH);
  endfunction

  function automatic bit exp_valid();
    return !RST && (m_pc.size() != 0) && !REDIRECT;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the reference
  always @(negedge CLK) begin
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_pcd;
    e_req   = exp_req();
    e_valid = exp_valid();
    if (RST)           e_pcd = RESET_PC;
    else if (REDIRECT) e_pcd = {REDIRECT_PC[31:2], 2'b00};
    else if (e_req && IMEM_GNT) e_pcd = PC_Q + 32'd4;
    else               e_pcd = PC_Q;
    chk("imem_req", {31'h0, IMEM_REQ}, {31'h0, e_req});
    chk("pc_d", PC_D, e_pcd);
    chk("if_valid", {31'h0, IF_VALID}, {31'h0, e_valid});
    if (e_req) chk("imem_addr", IMEM_ADDR, {PC_Q[31:2], 2'b00});
    if (e_valid) begin
      chk("if_pc", IF_PC, m_pc[0]);
      chk("if_instr", IF_INSTR, m_ins[0]);
    end
    if (IF_VALID === 1'b1 && IF_READY) begin
      got_pc.push_back(IF_PC);
      got_ins.push_back(IF_INSTR);
    end
  end

  // reference update at the clock edge
  always @(posedge CLK) begin
    bit req;
    bit pop;
    req = exp_req();
    pop = exp_valid() && IF_READY;
    if (RST) begin
      m_pc.delete(); m_ins.delete();
      m_out = 1'b0; m_stale = 1'b0;
    end else if (REDIRECT) begin
      m_pc.delete(); m_ins.delete();
      if (m_out) begin
        if (IMEM_RVALID) begin m_out = 1'b0; m_stale = 1'b0; end
        else m_stale = 1'b1;
      end else if (req && IMEM_GNT) begin
        m_out = 1'b1; m_stale = 1'b1;
      end
    end else begin
      if (pop) begin void'(m_pc.pop_front()); void'(m_ins.pop_front()); end
      if (m_out) begin
        if (IMEM_RVALID) begin
          if (!m_stale) begin m_pc.push_back(m_addr); m_ins.push_back(IMEM_RDATA); end
          m_out = 1'b0; m_stale = 1'b0;
        end
      end else if (req && IMEM_GNT) begin
        m_out = 1'b1; m_stale = 1'b0; m_addr = {PC_Q[31:2], 2'b00};
      end
    end
  end

  // one clock: sample outputs, then advance pc register and memory after the edge
  task automatic cycle();
    @(negedge CLK);
    s_req = IMEM_REQ; s_addr = IMEM_ADDR; s_pcd = PC_D;
    s_valid = IF_VALID; s_pc = IF_PC; s_ins = IF_INSTR;
    @(posedge CLK);
    #1;
    PC_Q = s_pcd;
    if (IMEM_RVALID) env_pend = 1'b0;
    if (!RST && s_req && IMEM_GNT) begin
      env_pend = 1'b1; env_addr = s_addr; env_wait = lat - 1;
    end else if (env_pend && env_wait > 0) begin
      env_wait--;
    end
    IMEM_RVALID = env_pend && (env_wait == 0);
    IMEM_RDATA  = IMEM_RVALID ? mem_word(env_addr) : 32'hDEAD_BEEF;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    RST = 1'b1; REDIRECT = 1'b0; IMEM_GNT = 1'b0; IF_READY = 1'b1;
    env_pend = 1'b0; IMEM_RVALID = 1'b0; lat = 1;
    cycles(2);
    RST = 1'b0;
    got_pc.delete(); got_ins.delete();
  endtask

  initial begin
    // reset values
    do_reset();
    chk("rst_req", {31'h0, s_req}, 32'h0);
    chk("rst_pcd", s_pcd, RESET_PC);
    chk("rst_valid", {31'h0, s_valid}, 32'h0);

    // 1: zero-wait streaming
    IMEM_GNT = 1'b1;
    cycles(10);
    chk("t1_count", got_pc.size(), 32'd4);
    chk("t1_pc0", got_pc[0], 32'h0);
    chk("t1_pc1", got_pc[1], 32'h4);
    chk("t1_pc2", got_pc[2], 32'h8);
    chk("t1_pc3", got_pc[3], 32'hC);
    chk("t1_ins1", got_ins[1], 32'hC0DE_0004);

    // 2: backpressure fills the buffer
    do_reset();
    IMEM_GNT = 1'b1; IF_READY = 1'b0;
    cycles(10);
    chk("t2_req", {31'h0, s_req}, 32'h0);
    chk("t2_pcq", PC_Q, 32'h8);
    chk("t2_valid", {31'h0, s_valid}, 32'h1);
    chk("t2_head", s_pc, 32'h0);
    IF_READY = 1'b1;
    cycles(8);
    chk("t2_pc0", got_pc[0], 32'h0);
    chk("t2_pc1", got_pc[1], 32'h4);
    chk("t2_pc2", got_pc[2], 32'h8);

    // 3: redirect on the grant cycle
    do_reset();
    IMEM_GNT = 1'b1;
    cycles(2);
    REDIRECT = 1'b1; REDIRECT_PC = 32'h400;
    cycle();
    chk("t3_addr", s_addr, 32'h4);
    chk("t3_pcd", s_pcd, 32'h400);
    chk("t3_valid", {31'h0, s_valid}, 32'h0);
    REDIRECT = 1'b0;
    cycles(6);
    chk("t3_pc0", got_pc[0], 32'h400);
    chk("t3_ins0", got_ins[0], 32'hC0DE_0400);

    // 4: unaligned redirect target, grant withheld
    do_reset();
    REDIRECT = 1'b1; REDIRECT_PC = 32'h203;
    cycle();
    chk("t4_pcd", s_pcd, 32'h200);
    REDIRECT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t4_req", {31'h0, s_req}, 32'h1);
      chk("t4_addr", s_addr, 32'h200);
    end
    IMEM_GNT = 1'b1;
    cycle();
    chk("t4_pcd_inc", s_pcd, 32'h204);
    cycles(3);
    chk("t4_pc0", got_pc[0], 32'h200);

    // 5: PC wrap, then reset while a response is outstanding
    do_reset();
    REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFF_FFFC;
    cycle();
    REDIRECT = 1'b0; IMEM_GNT = 1'b1; lat = 3;
    cycle();
    chk("t5_addr", s_addr, 32'hFFFF_FFFC);
    chk("t5_wrap", s_pcd, 32'h0);
    IMEM_GNT = 1'b0; RST = 1'b1;
    cycle();
    chk("t5_rst_valid", {31'h0, s_valid}, 32'h0);
    chk("t5_rst_pcd", s_pcd, RESET_PC);
    chk("t5_rst_req", {31'h0, s_req}, 32'h0);
    RST = 1'b0;
    cycle();
    chk("t5_post_pcd", s_pcd, RESET_PC);
    cycle();
    cycle();
    chk("t5_late_valid", {31'h0, s_valid}, 32'h0);
    IMEM_GNT = 1'b1; lat = 1;
    cycles(4);
    chk("t5_pc0", got_pc[0], RESET_PC);
    chk("t5_ins0", got_ins[0], 32'hC0DE_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
